jt900h_ramarb: RTL and testbench

Two-requester arbiter and sequencer for the 16-bit byte-enabled work RAM behind the jt900h core. Port A is the CPU bus: 16-bit data, 2-bit lane write enables. Port B is the byte-wide dump/debug DMA port, used for register/memory dump and preload. The block issues one RAM access at a time, waits the RAM read latency, and returns data with a one-cycle ready pulse. It sits between jt900h and the RAM in the top level.

---
 rtl/jt900h_pkg.sv | 24 ++
 rtl/jt900h_ramarb_lane.sv | 19 +
 rtl/jt900h_ramarb.sv | 164 ++++++++++++++++
 tb/tb_jt900h_ramarb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h work-RAM arbiter: FSM encoding, port ids
// and the RAM access payload.
package jt900h_pkg;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMP = 1'b1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    we;
        logic          rd;
    } ram_req_t;

endpackage

// File: rtl/jt900h_ramarb_lane.sv
// Byte-lane steering for the byte-wide dump port: replicate the write byte,
// pick the lane enable and select the read byte from address bit 0.
module jt900h_ramarb_lane
    import jt900h_pkg::*;
(
    input  logic          i_addr0,
    input  logic [BW-1:0] i_din,
    input  logic [DW-1:0] i_rdata,
    output logic [1:0]    o_we_c,
    output logic [DW-1:0] o_din_c,
    output logic [BW-1:0] o_dout_c
);

    // Little-endian: odd byte addresses live in bits 15:8
    assign o_we_c   = i_addr0 ? 2'b10 : 2'b01;
    assign o_din_c  = {i_din, i_din};
    assign o_dout_c = i_addr0 ? i_rdata[15:8] : i_rdata[7:0];

endmodule

// File: rtl/jt900h_ramarb.sv
// Two-port work-RAM arbiter: CPU word port and byte-wide dump port share one
// RAM, one access at a time, with starvation protection for the dump port.
module jt900h_ramarb
    import jt900h_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic [1:0]    cpu_we,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_rdy,
    input  logic [AW-1:0] dmp_addr,
    input  logic [BW-1:0] dmp_din,
    input  logic          dmp_we,
    input  logic          dmp_rd,
    output logic [BW-1:0] dmp_dout,
    output logic          dmp_rdy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [1:0]    ram_we,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam int unsigned CW = 2;
    localparam int unsigned SW = 4;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    ram_req_t      r_req;
    ram_req_t      w_req;
    logic          r_port;
    logic          r_wr;
    logic [CW-1:0] r_wcnt;
    logic [SW-1:0] r_starve;
    logic          r_cpu_rdy;
    logic          r_dmp_rdy;
    logic [DW-1:0] r_cpu_dout;
    logic [BW-1:0] r_dmp_dout;
    logic          r_busy;

    logic          w_a_req;
    logic          w_b_req;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_capture;
    logic [1:0]    w_dmp_we;
    logic [DW-1:0] w_dmp_din;
    logic [BW-1:0] w_dmp_byte;
    logic          w_unused;

    assign w_unused = cpu_addr[0];

    assign w_a_req   = cpu_rd | (|cpu_we);
    assign w_b_req   = dmp_rd | dmp_we;
    assign w_grant_b = (r_state == ST_IDLE) & w_b_req &
                       (~w_a_req | (r_starve == SW'(STARVE_MAX)));
    assign w_grant_a = (r_state == ST_IDLE) & w_a_req & ~w_grant_b;
    assign w_capture = (w_state_nx == ST_DONE) & ~r_wr;

    jt900h_ramarb_lane u_lane (
        .i_addr0  (dmp_addr[0]),
        .i_din    (dmp_din),
        .i_rdata  (ram_dout),
        .o_we_c   (w_dmp_we),
        .o_din_c  (w_dmp_din),
        .o_dout_c (w_dmp_byte)
    );

    // Access payload of the port being granted; a write overrides rd
    always_comb begin
        w_req = '0;
        if (w_grant_b) begin
            w_req.addr = {dmp_addr[AW-1:1], 1'b0};
            w_req.din  = w_dmp_din;
            w_req.we   = dmp_we ? w_dmp_we : 2'b00;
            w_req.rd   = ~dmp_we;
        end else begin
            w_req.addr = {cpu_addr[AW-1:1], 1'b0};
            w_req.din  = cpu_din;
            w_req.we   = cpu_we;
            w_req.rd   = ~(|cpu_we);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_a | w_grant_b) w_state_nx = ST_ISSUE;
            ST_ISSUE: w_state_nx = (r_wr || LATENCY == 1) ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (r_wcnt == CW'(1)) w_state_nx = ST_DONE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else if (cen)
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req      <= '0;
            r_port     <= PORT_CPU;
            r_wr       <= 1'b0;
            r_wcnt     <= '0;
            r_starve   <= '0;
            r_cpu_rdy  <= 1'b0;
            r_dmp_rdy  <= 1'b0;
            r_cpu_dout <= '0;
            r_dmp_dout <= '0;
            r_busy     <= 1'b0;
        end else if (cen) begin
            r_req.we  <= 2'b00;
            r_req.rd  <= 1'b0;
            r_cpu_rdy <= 1'b0;
            r_dmp_rdy <= 1'b0;
            r_busy    <= (w_state_nx != ST_IDLE);
            if (w_grant_a | w_grant_b) begin
                r_req  <= w_req;
                r_port <= w_grant_b;
                r_wr   <= |w_req.we;
                r_wcnt <= CW'(LATENCY - 1);
                // Count CPU wins only while the dump port is left waiting
                if (w_grant_b || !w_b_req)
                    r_starve <= '0;
                else if (r_starve != SW'(STARVE_MAX))
                    r_starve <= r_starve + SW'(1);
            end
            if (r_state == ST_WAIT)
                r_wcnt <= r_wcnt - CW'(1);
            if (w_capture) begin
                if (r_port == PORT_DMP)
                    r_dmp_dout <= w_dmp_byte;
                else
                    r_cpu_dout <= ram_dout;
            end
            if (w_state_nx == ST_DONE) begin
                r_cpu_rdy <= (r_port == PORT_CPU);
                r_dmp_rdy <= (r_port == PORT_DMP);
            end
        end
    end

    assign ram_addr = r_req.addr;
    assign ram_din  = r_req.din;
    assign ram_we   = r_req.we;
    assign ram_rd   = r_req.rd;
    assign cpu_dout = r_cpu_dout;
    assign cpu_rdy  = r_cpu_rdy;
    assign dmp_dout = r_dmp_dout;
    assign dmp_rdy  = r_dmp_rdy;
    assign busy     = r_busy;

endmodule

// File: tb/tb_jt900h_ramarb.sv
// Directed bench for jt900h_ramarb: u1 runs with LATENCY=1 (CPU/dump/starvation),
// u3 with LATENCY=3 (clock-enable stretching and reset during WAIT).
module tb_jt900h_ramarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cen;
    logic [23:0] c_addr, d_addr, c3_addr;
    logic [15:0] c_din;
    logic [1:0]  c_we, c3_we;
    logic        c_rd, c3_rd, d_we, d_rd;
    logic [7:0]  d_din;

    logic [15:0] c_dout1, r_din1, r_dout1, c_dout3, r_din3, r_dout3;
    logic        c_rdy1, d_rdy1, r_rd1, busy1, c_rdy3, d_rdy3, r_rd3, busy3;
    logic [7:0]  d_dout1, d_dout3;
    logic [23:0] r_addr1, r_addr3;
    logic [1:0]  r_we1, r_we3;

    jt900h_ramarb #(.LATENCY(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_addr(c_addr), .cpu_din(c_din), .cpu_we(c_we), .cpu_rd(c_rd),
        .cpu_dout(c_dout1), .cpu_rdy(c_rdy1),
        .dmp_addr(d_addr), .dmp_din(d_din), .dmp_we(d_we), .dmp_rd(d_rd),
        .dmp_dout(d_dout1), .dmp_rdy(d_rdy1),
        .ram_addr(r_addr1), .ram_din(r_din1), .ram_we(r_we1), .ram_rd(r_rd1),
        .ram_dout(r_dout1), .busy(busy1)
    );

    jt900h_ramarb #(.LATENCY(3), .STARVE_MAX(4)) u3 (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_addr(c3_addr), .cpu_din(16'h0000), .cpu_we(c3_we), .cpu_rd(c3_rd),
        .cpu_dout(c_dout3), .cpu_rdy(c_rdy3),
        .dmp_addr(24'h000000), .dmp_din(8'h00), .dmp_we(1'b0), .dmp_rd(1'b0),
        .dmp_dout(d_dout3), .dmp_rdy(d_rdy3),
        .ram_addr(r_addr3), .ram_din(r_din3), .ram_we(r_we3), .ram_rd(r_rd3),
        .ram_dout(r_dout3), .busy(busy3)
    );

    // Shared RAM: asynchronous read, lane writes from u1 only, plus a poke port
    logic [15:0] mem [0:255];
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [15:0] poke_val;

    assign r_dout1 = mem[r_addr1[8:1]];
    assign r_dout3 = mem[r_addr3[8:1]];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_val;
        else if (cen) begin
            if (r_we1[0]) mem[r_addr1[8:1]][7:0]  <= r_din1[7:0];
            if (r_we1[1]) mem[r_addr1[8:1]][15:8] <= r_din1[15:8];
        end
    end

    // Record what u1 put on the RAM bus and the order of its completions
    int          n_we = 0, n_rd = 0;
    logic [1:0]  l_we;
    logic [23:0] l_waddr, l_raddr;
    logic [15:0] l_wdin;
    int          seq_q[$];

    always @(posedge clk) begin
        if (r_we1 != 2'b00) begin
            n_we++; l_we = r_we1; l_waddr = r_addr1; l_wdin = r_din1;
        end
        if (r_rd1) begin
            n_rd++; l_raddr = r_addr1;
        end
        if (c_rdy1) seq_q.push_back(0);
        if (d_rdy1) seq_q.push_back(1);
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [15:0] val);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic cpu_xfer(input logic [23:0] a, input logic [15:0] d,
                            input logic [1:0] we, input logic rd, output int edges);
        c_addr = a; c_din = d; c_we = we; c_rd = rd; edges = 0;
        do begin @(negedge clk); edges++; end while (!c_rdy1 && edges < 40);
        c_we = 2'b00; c_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic dmp_xfer(input logic [23:0] a, input logic [7:0] d,
                            input logic we, input logic rd, output int edges);
        d_addr = a; d_din = d; d_we = we; d_rd = rd; edges = 0;
        do begin @(negedge clk); edges++; end while (!d_rdy1 && edges < 40);
        d_we = 1'b0; d_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          e, n0, rdys;
        logic        h_rd;
        logic [5:0]  pat;

        rst = 1'b0; cen = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        c_addr = '0; c_din = '0; c_we = '0; c_rd = 1'b0;
        d_addr = '0; d_din = '0; d_we = 1'b0; d_rd = 1'b0;
        c3_addr = '0; c3_we = '0; c3_rd = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  {31'd0, busy1}, 32'd0);
        chk("rst_rdy",   {30'd0, c_rdy1, d_rdy1}, 32'd0);
        chk("rst_ram",   {5'd0, r_addr1, r_we1, r_rd1}, 32'd0);
        chk("rst_douts", {8'd0, c_dout1, d_dout1}, 32'd0);

        poke(8'h08, 16'hBEEF);
        poke(8'h10, 16'h0077);
        rst = 1'b1;
        @(negedge clk);

        // CPU read, then odd address maps onto the same word
        n0 = n_rd;
        cpu_xfer(24'h000010, 16'h0000, 2'b00, 1'b1, e);
        chk("cpu_rd_lat",    e, 2);
        chk("cpu_rd_data",   c_dout1, 16'hBEEF);
        chk("cpu_rd_strobe", n_rd - n0, 1);
        chk("cpu_rd_addr",   l_raddr, 24'h000010);
        chk("cpu_idle_after", {30'd0, c_rdy1, busy1}, 32'd0);
        cpu_xfer(24'h000011, 16'h0000, 2'b00, 1'b1, e);
        chk("cpu_odd_addr",  l_raddr, 24'h000010);
        chk("cpu_odd_data",  c_dout1, 16'hBEEF);

        // CPU upper-lane write
        n0 = n_we;
        cpu_xfer(24'h000020, 16'h12AB, 2'b10, 1'b0, e);
        chk("cpu_wr_lat",   e, 2);
        chk("cpu_wr_pulse", n_we - n0, 1);
        chk("cpu_wr_we",    l_we, 2'b10);
        chk("cpu_wr_mem",   mem[8'h10], 16'h1277);

        // rd and we together is a write
        n0 = n_rd;
        cpu_xfer(24'h000030, 16'h3344, 2'b01, 1'b1, e);
        chk("cpu_rdwe_nord", n_rd - n0, 0);
        chk("cpu_rdwe_mem",  mem[8'h18][7:0], 8'h44);

        // Dump write/read with byte steering
        poke(8'h10, 16'h0077);
        dmp_xfer(24'h000021, 8'h5A, 1'b1, 1'b0, e);
        chk("dmp_wr_lat",  e, 2);
        chk("dmp_wr_we",   l_we, 2'b10);
        chk("dmp_wr_din",  l_wdin, 16'h5A5A);
        chk("dmp_wr_addr", l_waddr, 24'h000020);
        dmp_xfer(24'h000021, 8'h00, 1'b0, 1'b1, e);
        chk("dmp_rd_hi",   d_dout1, 8'h5A);
        dmp_xfer(24'h000020, 8'h00, 1'b0, 1'b1, e);
        chk("dmp_rd_lo",   d_dout1, 8'h77);
        dmp_xfer(24'h000022, 8'hC3, 1'b1, 1'b0, e);
        chk("dmp_wr_even_we", l_we, 2'b01);
        chk("dmp_wr_even_mem", mem[8'h11][7:0], 8'hC3);

        // Starvation: CPU hammers, dump waits for its forced slot
        seq_q.delete();
        c_addr = 24'h000010; c_rd = 1'b1; d_addr = 24'h000021; d_rd = 1'b1;
        for (int i = 0; i < 80 && seq_q.size() < 6; i++) begin
            @(negedge clk);
            if (d_rdy1) d_rd = 1'b0;
        end
        c_rd = 1'b0; d_rd = 1'b0;
        chk("starve_count", seq_q.size(), 6);
        pat = '0;
        for (int k = 0; k < 6 && k < seq_q.size(); k++) pat[k] = seq_q[k][0];
        chk("starve_order", pat, 6'b010000);
        repeat (2) @(negedge clk);
        chk("starve_clear", u1.r_starve, 4'd0);

        // LATENCY=3 read with cen toggling every clock
        poke(8'h40, 16'hCAFE);
        cen = 1'b0; c3_addr = 24'h000080; c3_rd = 1'b1; e = 0; h_rd = 1'b0;
        do begin
            @(negedge clk); e++;
            if (e == 3) h_rd = r_rd3;
            cen = ~cen;
        end while (!c_rdy3 && e < 60);
        c3_rd = 1'b0;
        chk("cen_lat",    e, 8);
        chk("cen_data",   c_dout3, 16'hCAFE);
        chk("cen_rd_hold", {31'd0, h_rd}, 32'd1);
        @(negedge clk);
        chk("cen_rdy_stretch", {30'd0, c_rdy3, busy3}, 32'd3);
        cen = 1'b1;
        @(negedge clk);
        chk("cen_rdy_end", {31'd0, c_rdy3}, 32'd0);
        @(negedge clk);

        // Reset while u3 sits in WAIT, then a clean access
        poke(8'h41, 16'h1357);
        c3_addr = 24'h000082; c3_rd = 1'b1;
        repeat (2) @(negedge clk);
        chk("wait_busy", {31'd0, busy3}, 32'd1);
        rst = 1'b0; c3_rd = 1'b0;
        @(negedge clk);
        chk("wait_rst_idle", {30'd0, busy3, c_rdy3}, 32'd0);
        rst = 1'b1; rdys = 0;
        repeat (6) begin @(negedge clk); if (c_rdy3) rdys++; end
        chk("wait_rst_norrdy", rdys, 0);
        c3_rd = 1'b1; e = 0;
        do begin @(negedge clk); e++; end while (!c_rdy3 && e < 40);
        c3_rd = 1'b0;
        chk("post_rst_lat",  e, 4);
        chk("post_rst_data", c_dout3, 16'h1357);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
